lt_symbol_encoder: RTL and testbench
====================================

Name: lt_symbol_encoder

Overview:
- Downstream consumer of the LT degree generator's 9-bit degree stream.
- For each accepted degree d, draws d pseudo-random source-symbol indices from a 16-bit LFSR and reads each source word from an external synchronous source RAM (1-cycle read latency).
- XOR-accumulates the returned words into one encoded symbol and presents it, with its degree, on a valid/ready output.

Parameters:
- IDX_W, 9, source index width; K = 2^IDX_W source symbols (no modulo logic).
- DATA_W, 32, source/encoded symbol width.
- LFSR_SEED, 16'h0001, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- degree_in  input  9  degree from generator; value 0 treated as 1.
- degree_valid  input  1  degree_in valid.
- degree_ready  output  1  block accepts degree this cycle.
- src_rd_en  output  1  source RAM read strobe.
- src_addr  output  IDX_W  source RAM read address.
- src_rd_data  input  DATA_W  RAM data, valid the cycle after src_rd_en.
- sym_valid  output  1  encoded symbol valid.
- sym_ready  input  1  downstream accepts symbol.
- sym_data  output  DATA_W  XOR of selected source words.
- sym_degree  output  9  effective degree used (1..511).

Behaviour:
- Reset (async, rst_n low): state=IDLE; LFSR=LFSR_SEED; all counters and accumulator cleared.
- Output reset values: degree_ready=0, src_rd_en=0, src_addr=0, sym_valid=0, sym_data=0, sym_degree=0.
- All outputs are registered.
- IDLE:
  - degree_ready=1 from the first cycle after reset release.
  - On degree_valid && degree_ready: latch d=(degree_in==0)?1:degree_in; cnt=0; acc=0; go ISSUE; degree_ready=0 next cycle.
- ISSUE:
  - Each cycle: src_rd_en=1, src_addr=lfsr[IDX_W-1:0]; LFSR advances once per issued read; cnt++.
  - After issuing read number d, go WAIT; src_rd_en deasserts.
- Data path:
  - rd_pending = src_rd_en delayed 1 cycle.
  - When rd_pending=1: acc <= acc ^ src_rd_data.
  - Duplicate indices are not suppressed; they cancel by XOR, which is intended LT behaviour.
- WAIT: one cycle to absorb the last returned word, then go OUT.
- OUT:
  - sym_valid=1; sym_data=acc; sym_degree=d; all held stable while sym_ready=0.
  - On sym_valid && sym_ready: sym_valid=0 and go IDLE; degree_ready=1 the following cycle.
- Cycle counts:
  - Degree acceptance to sym_valid = d+2 cycles.
  - Minimum symbol period = d+4 cycles.
- LFSR:
  - 16-bit Galois, right shift, feedback mask 16'hB400.
  - next = lfsr[0] ? (lfsr>>1)^16'hB400 : lfsr>>1.
  - Never advances outside ISSUE.
- Boundaries:
  - degree_valid while busy: ignored, since degree_ready=0. The upstream generator's valid is constant, so degrees are simply skipped/held by the upstream; no loss is specified at this block.
  - d=511: cnt is 9 bits and compares against d, with no overflow.
  - Reset mid-symbol: partial acc is discarded, no output is produced, and the LFSR returns to LFSR_SEED.
  - sym_ready held low indefinitely: block stalls in OUT, and src_rd_en stays 0.

Optional Feature:
- Macro LT_SEED_OUT_EN.
- When defined:
  - Adds output port sym_seed [15:0].
  - sym_seed carries the LFSR value captured at degree acceptance, registered and held with sym_data, so the decoder can regenerate the index set.
  - Reset value 0.
- When undefined: no port and no capture register. Behaviour is otherwise identical.

Decomposition:
- Shared package lt_pkg:
  - constants LT_DEG_W=9, LT_LFSR_W=16, LT_LFSR_MASK=16'hB400;
  - enum lt_enc_state_t {IDLE, ISSUE, WAIT, OUT}.
- One sub-module, lt_lfsr16, with ports clk, rst_n, adv, seed parameter and state output.
- The LFSR is reused by the future decoder-side index regenerator.

Test Plan:
- Source RAM model word[i]=i; seed 0x0001. First indices are 0x001, 0x000, 0x000, 0x100, 0x080 (LFSR 0x0001, 0xB400, 0x5A00, 0x2D00, 0x1680).
- degree_in=1 -> one read at addr 0x001; sym_valid 3 cycles after acceptance; sym_data=0x1, sym_degree=1.
- Next degree_in=2 -> reads 0x000 and 0x000; sym_data=0x0 (duplicate cancels), sym_degree=2.
- Next degree_in=2 -> reads 0x100 and 0x080; sym_data=0x180. Hold sym_ready=0 for 5 cycles -> outputs stable and degree_ready=0 throughout.
- degree_in=0 after reset -> treated as 1; sym_degree=1, sym_data=0x1.
- degree_in=511 -> exactly 511 src_rd_en pulses; sym_valid at cycle 513 after acceptance; sym_data matches the reference model's XOR.
- Assert rst_n=0 mid-ISSUE of a degree-10 symbol -> no sym_valid; after release the next degree=1 reads addr 0x001 again (LFSR reseeded).

Source files
------------

// File: rtl/lt_pkg.sv
// Shared LT coding definitions: degree width, LFSR geometry and encoder states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lt_pkg;

    localparam int          LT_DEG_W     = 9;
    localparam int          LT_LFSR_W    = 16;
    localparam logic [15:0] LT_LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } lt_enc_state_t;

    // One step of the right-shifting Galois LFSR. The decoder-side index
    // regenerator uses the same step, so both ends walk identical sequences.
    function automatic logic [LT_LFSR_W-1:0] lt_lfsr_step(input logic [LT_LFSR_W-1:0] cur);
        return cur[0] ? ((cur >> 1) ^ LT_LFSR_MASK) : (cur >> 1);
    endfunction

endpackage

// File: rtl/lt_lfsr16.sv
// 16-bit Galois LFSR index source, advancing one step per adv pulse.
// Latency: state reflects an adv pulse on the following cycle.
// Backpressure: none; it holds its value whenever adv is low.
//
// Ports: clk, rst_n (async, active low, reloads SEED), adv (step enable),
//        state (current LFSR value).
module lt_lfsr16
    import lt_pkg::*;
#(
    parameter logic [LT_LFSR_W-1:0] SEED = 16'h0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    output logic [LT_LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (adv) begin
            state <= lt_lfsr_step(state);
        end
    end

endmodule

// File: rtl/lt_symbol_encoder.sv
// LT encoder: per degree d, reads d LFSR-chosen source words and XORs them into one symbol.
// Latency: degree acceptance to sym_valid is d+2 cycles; back-to-back symbol period is d+4.
// Backpressure: sym_ready low holds the symbol and stalls in OUT; degree_ready stays low while busy.
//
// Ports: clk, rst_n (async, active low); degree_in/degree_valid/degree_ready (degree input);
//        src_rd_en/src_addr/src_rd_data (synchronous source RAM, 1-cycle read latency);
//        sym_valid/sym_ready/sym_data/sym_degree (encoded symbol output).
// Optional: define LT_SEED_OUT_EN to add sym_seed, the LFSR value at degree acceptance.
module lt_symbol_encoder
    import lt_pkg::*;
#(
    parameter int                   IDX_W     = 9,
    parameter int                   DATA_W    = 32,
    parameter logic [LT_LFSR_W-1:0] LFSR_SEED = 16'h0001
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LT_DEG_W-1:0] degree_in,
    input  logic                degree_valid,
    output logic                degree_ready,
    output logic                src_rd_en,
    output logic [IDX_W-1:0]    src_addr,
    input  logic [DATA_W-1:0]   src_rd_data,
    output logic                sym_valid,
    input  logic                sym_ready,
    output logic [DATA_W-1:0]   sym_data,
`ifdef LT_SEED_OUT_EN
    output logic [LT_LFSR_W-1:0] sym_seed,
`endif
    output logic [LT_DEG_W-1:0] sym_degree
);

    lt_enc_state_t        state, state_nxt;
    logic [LT_DEG_W-1:0]  deg, deg_nxt;
    logic [LT_DEG_W-1:0]  cnt, cnt_nxt;
    logic                 rd_en_nxt;
    logic                 lfsr_adv;
    logic                 accept;
    logic                 rd_pending;
    logic [LT_LFSR_W-1:0] lfsr_state;

    assign accept = degree_valid && degree_ready;

    lt_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (lfsr_adv),
        .state (lfsr_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            deg   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            deg   <= deg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ISSUE leaves only once cnt has reached d, i.e. one cycle after the last
    // read was registered; WAIT then covers that read's returning word, which
    // puts sym_valid and the final accumulator update on the same edge.
    always_comb begin
        state_nxt = state;
        deg_nxt   = deg;
        cnt_nxt   = cnt;
        rd_en_nxt = 1'b0;
        lfsr_adv  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    deg_nxt   = (degree_in == '0) ? LT_DEG_W'(1) : degree_in;
                    cnt_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == deg) begin
                    state_nxt = WAIT;
                end else begin
                    rd_en_nxt = 1'b1;
                    lfsr_adv  = 1'b1;
                    cnt_nxt   = cnt + LT_DEG_W'(1);
                end
            end
            WAIT: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (sym_valid && sym_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // sym_data doubles as the XOR accumulator; it only moves while reads are
    // returning, so it is naturally stable throughout OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            degree_ready <= 1'b0;
            src_rd_en    <= 1'b0;
            src_addr     <= '0;
            rd_pending   <= 1'b0;
            sym_valid    <= 1'b0;
            sym_data     <= '0;
            sym_degree   <= '0;
        end else begin
            degree_ready <= (state_nxt == IDLE);
            sym_valid    <= (state_nxt == OUT);
            src_rd_en    <= rd_en_nxt;
            rd_pending   <= src_rd_en;
            if (rd_en_nxt) begin
                src_addr <= lfsr_state[IDX_W-1:0];
            end
            if (accept) begin
                sym_data <= '0;
            end else if (rd_pending) begin
                sym_data <= sym_data ^ src_rd_data;
            end
            if (state == WAIT) begin
                sym_degree <= deg;
            end
        end
    end

`ifdef LT_SEED_OUT_EN
    // The LFSR value at acceptance is the first index seed of this symbol;
    // the decoder replays the index set from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_seed <= '0;
        end else if (accept) begin
            sym_seed <= lfsr_state;
        end
    end
`endif

endmodule

// File: tb/tb_lt_symbol_encoder.sv
// Self-checking bench for lt_symbol_encoder with a word[i]=i source RAM model.
// Latency: n/a.
// Backpressure: exercises sym_ready stalls and reset mid-symbol.
module tb_lt_symbol_encoder;

    localparam int IDX_W  = 9;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [8:0]        degree_in;
    logic              degree_valid;
    logic              degree_ready;
    logic              src_rd_en;
    logic [IDX_W-1:0]  src_addr;
    logic [DATA_W-1:0] src_rd_data;
    logic              sym_valid;
    logic              sym_ready;
    logic [DATA_W-1:0] sym_data;
    logic [8:0]        sym_degree;
`ifdef LT_SEED_OUT_EN
    logic [15:0]       sym_seed;
`endif

    lt_symbol_encoder #(
        .IDX_W     (IDX_W),
        .DATA_W    (DATA_W),
        .LFSR_SEED (16'h0001)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .degree_in    (degree_in),
        .degree_valid (degree_valid),
        .degree_ready (degree_ready),
        .src_rd_en    (src_rd_en),
        .src_addr     (src_addr),
        .src_rd_data  (src_rd_data),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_data     (sym_data),
`ifdef LT_SEED_OUT_EN
        .sym_seed     (sym_seed),
`endif
        .sym_degree   (sym_degree)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM: word[i] = i, one-cycle registered read.
    always @(posedge clk) begin
        if (src_rd_en) src_rd_data <= {{(DATA_W-IDX_W){1'b0}}, src_addr};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard state
    logic [IDX_W-1:0]  exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [8:0]        exp_deg_q[$];
`ifdef LT_SEED_OUT_EN
    logic [15:0]       exp_seed_q[$];
`endif
    logic [15:0]       m_lfsr;
    int                rd_cnt;

    function automatic logic [15:0] m_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Monitor: reads and symbol handshakes observed on the falling edge,
    // i.e. the values the DUT presents to the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (src_rd_en) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) check("rd_unexpected", exp_addr_q.size(), 1);
                else check("rd_addr", src_addr, exp_addr_q.pop_front());
            end
            if (sym_valid && sym_ready) begin
                if (exp_data_q.size() == 0) begin
                    check("sym_unexpected", exp_data_q.size(), 1);
                end else begin
                    check("sym_data", sym_data, exp_data_q.pop_front());
                    check("sym_degree", sym_degree, exp_deg_q.pop_front());
`ifdef LT_SEED_OUT_EN
                    check("sym_seed", sym_seed, exp_seed_q.pop_front());
`endif
                end
            end
        end
    end

    task automatic issue_deg(input logic [8:0] din);
        int t;
        int eff;
        logic [DATA_W-1:0] acc;
        t = 0;
        while (!degree_ready && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        check("degree_ready_wait", degree_ready, 1);
        eff = (din == 0) ? 1 : int'(din);
        acc = '0;
`ifdef LT_SEED_OUT_EN
        exp_seed_q.push_back(m_lfsr);
`endif
        for (int i = 0; i < eff; i++) begin
            exp_addr_q.push_back(m_lfsr[IDX_W-1:0]);
            acc = acc ^ {{(DATA_W-IDX_W){1'b0}}, m_lfsr[IDX_W-1:0]};
            m_lfsr = m_step(m_lfsr);
        end
        exp_data_q.push_back(acc);
        exp_deg_q.push_back(9'(eff));
        rd_cnt = 0;
        degree_in    = din;
        degree_valid = 1'b1;
        @(posedge clk); #1;
        degree_valid = 1'b0;
    endtask

    task automatic run_sym(input logic [8:0] din, input int hold);
        int lat;
        int eff;
        logic [DATA_W-1:0] held;
        eff = (din == 0) ? 1 : int'(din);
        sym_ready = (hold == 0);
        issue_deg(din);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!sym_valid && lat < 2000);
        check("latency", lat, eff + 2);
        check("rd_count", rd_cnt, eff);
        if (hold > 0) begin
            held = (exp_data_q.size() > 0) ? exp_data_q[0] : '0;
            for (int i = 0; i < hold; i++) begin
                check("stall_valid", sym_valid, 1);
                check("stall_data", sym_data, held);
                check("stall_degree_ready", degree_ready, 0);
                check("stall_rd_en", src_rd_en, 0);
                @(posedge clk); #1;
            end
            sym_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("valid_drop", sym_valid, 0);
        check("ready_return", degree_ready, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_deg_q.delete();
`ifdef LT_SEED_OUT_EN
        exp_seed_q.delete();
`endif
        m_lfsr = 16'h0001;
        #1;
        check("rst_sym_valid", sym_valid, 0);
        check("rst_rd_en", src_rd_en, 0);
        check("rst_degree_ready", degree_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_sym", sym_valid, 0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        degree_in    = '0;
        degree_valid = 1'b0;
        sym_ready    = 1'b1;
        m_lfsr       = 16'h0001;
        rd_cnt       = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_degree_ready", degree_ready, 0);
        check("reset_rd_en", src_rd_en, 0);
        check("reset_addr", src_addr, 0);
        check("reset_sym_valid", sym_valid, 0);
        check("reset_sym_data", sym_data, 0);
        check("reset_sym_degree", sym_degree, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", degree_ready, 1);

        run_sym(9'd1, 0);   // addr 0x001 -> 0x1
        run_sym(9'd2, 0);   // 0x000, 0x000 -> cancels to 0
        run_sym(9'd2, 5);   // 0x100, 0x080 -> 0x180, stalled 5 cycles

        do_reset();
        run_sym(9'd0, 0);   // degree 0 acts as 1 -> addr 0x001
        run_sym(9'd511, 0);

        // Reset in the middle of a degree-10 symbol.
        sym_ready = 1'b1;
        issue_deg(9'd10);
        repeat (3) @(posedge clk);
        #1;
        check("mid_issue_rd_en", src_rd_en, 1);
        do_reset();
        run_sym(9'd1, 0);   // LFSR reseeded -> addr 0x001 again

        repeat (3) @(posedge clk);
        #1;
        check("addr_queue_empty", exp_addr_q.size(), 0);
        check("sym_queue_empty", exp_data_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
